// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared sizes and types for the register file.
//   NUM_ADDR_BITS  address width
//   REG_WIDTH      entry/data width
//   NUM_REGS       entry count (2**NUM_ADDR_BITS)
//   addr_t, data_t address and data types
package reg_file_pkg;
  localparam int NUM_ADDR_BITS = 6;
  localparam int REG_WIDTH = 32;
  localparam int NUM_REGS = 2 ** NUM_ADDR_BITS;
  typedef logic [NUM_ADDR_BITS-1:0] addr_t;
  typedef logic [REG_WIDTH-1:0] data_t;
endpackage

// File: rtl/reg_file_if.sv
// reg_file_if: write port plus three read ports of the register file.
//   writeEnable, wrAddr, wrData        write request (master -> slave)
//   rdAddrA/B/C                        read addresses (master -> slave)
//   rdDataA/B/C                        read data (slave -> master)
interface reg_file_if;
  import reg_file_pkg::*;
  logic writeEnable;
  addr_t wrAddr;
  data_t wrData;
  addr_t rdAddrA;
  addr_t rdAddrB;
  addr_t rdAddrC;
  data_t rdDataA;
  data_t rdDataB;
  data_t rdDataC;
  modport master (
    output writeEnable, wrAddr, wrData, rdAddrA, rdAddrB, rdAddrC,
    input  rdDataA, rdDataB, rdDataC
  );
  modport slave (
    input  writeEnable, wrAddr, wrData, rdAddrA, rdAddrB, rdAddrC,
    output rdDataA, rdDataB, rdDataC
  );
endinterface

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port: one asynchronous read mux with optional write forwarding.
//   mem     storage array
//   rdAddr  read address
//   fwdEn   write in flight and not in reset (RF_WRITE_BYPASS_EN only)
//   wrAddr  write address (RF_WRITE_BYPASS_EN only)
//   wrData  write data (RF_WRITE_BYPASS_EN only)
//   rdData  read data
module reg_file_rd_port
  import reg_file_pkg::*;
(
  input  data_t mem [NUM_REGS],
  input  addr_t rdAddr,
`ifdef RF_WRITE_BYPASS_EN
  input  logic  fwdEn,
  input  addr_t wrAddr,
  input  data_t wrData,
`endif
  output data_t rdData
);
`ifdef RF_WRITE_BYPASS_EN
  always_comb rdData = (fwdEn && rdAddr == wrAddr) ? wrData : mem[rdAddr];
`else
  always_comb rdData = mem[rdAddr];
`endif
endmodule

// File: rtl/reg_file.sv
// reg_file: 64x32 register file, one synchronous write port, three async read ports.
//   clk    clock, state changes on rising edge
//   rst_n  synchronous active-low reset, clears every entry, beats writes
//   bus    reg_file_if.slave: write port and read ports A/B/C
// Optional macro RF_WRITE_BYPASS_EN forwards wrData to any read port addressing
// wrAddr while a write is pending (write-first); without it reads are read-before-write.
module reg_file
  import reg_file_pkg::*;
(
  input logic clk,
  input logic rst_n,
  reg_file_if.slave bus
);
  data_t mem [NUM_REGS];
  always_ff @(posedge clk) begin
    if (!rst_n)
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    else if (bus.writeEnable)
      mem[bus.wrAddr] <= bus.wrData;
  end
`ifdef RF_WRITE_BYPASS_EN
  // forwarding must not expose data that the reset is about to discard
  logic fwdEn;
  always_comb fwdEn = rst_n && bus.writeEnable;
  reg_file_rd_port rdA (.mem(mem), .rdAddr(bus.rdAddrA), .fwdEn(fwdEn), .wrAddr(bus.wrAddr), .wrData(bus.wrData), .rdData(bus.rdDataA));
  reg_file_rd_port rdB (.mem(mem), .rdAddr(bus.rdAddrB), .fwdEn(fwdEn), .wrAddr(bus.wrAddr), .wrData(bus.wrData), .rdData(bus.rdDataB));
  reg_file_rd_port rdC (.mem(mem), .rdAddr(bus.rdAddrC), .fwdEn(fwdEn), .wrAddr(bus.wrAddr), .wrData(bus.wrData), .rdData(bus.rdDataC));
`else
  reg_file_rd_port rdA (.mem(mem), .rdAddr(bus.rdAddrA), .rdData(bus.rdDataA));
  reg_file_rd_port rdB (.mem(mem), .rdAddr(bus.rdAddrB), .rdData(bus.rdDataB));
  reg_file_rd_port rdC (.mem(mem), .rdAddr(bus.rdAddrC), .rdData(bus.rdDataC));
`endif
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed and randomized checks of reg_file against an array model.
module tb_reg_file;
  import reg_file_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  data_t model [NUM_REGS];
  reg_file_if bus0 ();
  reg_file_if bus1 ();
  reg_file dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  reg_file dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  assign bus1.writeEnable = bus0.writeEnable;
  assign bus1.wrAddr = bus0.wrAddr;
  assign bus1.wrData = bus0.wrData;
  assign bus1.rdAddrA = bus0.rdAddrA;
  assign bus1.rdAddrB = bus0.rdAddrB;
  assign bus1.rdAddrC = bus0.rdAddrC;
  always #5 clk = ~clk;

  task automatic check(string tag, data_t got, data_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic data_t expRd(addr_t a);
`ifdef RF_WRITE_BYPASS_EN
    if (rst_n && bus0.writeEnable && a == bus0.wrAddr) return bus0.wrData;
`endif
    return model[a];
  endfunction

  task automatic setW(logic we, addr_t a, data_t d);
    bus0.writeEnable = we;
    bus0.wrAddr = a;
    bus0.wrData = d;
  endtask

  task automatic setR(addr_t a, addr_t b, addr_t c);
    bus0.rdAddrA = a;
    bus0.rdAddrB = b;
    bus0.rdAddrC = c;
  endtask

  // model commits what the DUT sees at the coming edge, then steps past it
  task automatic tick();
    if (!rst_n)
      foreach (model[i]) model[i] = '0;
    else if (bus0.writeEnable)
      model[bus0.wrAddr] = bus0.wrData;
    @(posedge clk);
    #1;
  endtask

  task automatic checkPorts(string tag);
    #1;
    check({tag, "_A0"}, bus0.rdDataA, expRd(bus0.rdAddrA));
    check({tag, "_B0"}, bus0.rdDataB, expRd(bus0.rdAddrB));
    check({tag, "_C0"}, bus0.rdDataC, expRd(bus0.rdAddrC));
    check({tag, "_A1"}, bus1.rdDataA, expRd(bus1.rdAddrA));
    check({tag, "_B1"}, bus1.rdDataB, expRd(bus1.rdAddrB));
    check({tag, "_C1"}, bus1.rdDataC, expRd(bus1.rdAddrC));
  endtask

  initial begin
    foreach (model[i]) model[i] = 32'hDEAD_BEEF;
    setW(1'b1, 6'h03, 32'hAAAA_AAAA);
    setR('0, '0, '0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    setW(1'b0, '0, '0);
    for (int i = 0; i < NUM_REGS; i++) begin
      setR(addr_t'(i), addr_t'(NUM_REGS - 1 - i), addr_t'(i));
      #1;
      check("rst_A", bus0.rdDataA, '0);
      check("rst_B", bus0.rdDataB, '0);
      check("rst_C", bus0.rdDataC, '0);
    end
    setW(1'b1, 6'h01, 32'h1457_8BB0);
    tick();
    setW(1'b0, '0, '0);
    setR(6'h01, 6'h00, 6'h01);
    #1;
    check("t1_A", bus0.rdDataA, 32'h1457_8BB0);
    check("t1_C", bus0.rdDataC, 32'h1457_8BB0);
    check("t1_B", bus0.rdDataB, 32'h0);
    setW(1'b0, 6'h02, 32'h0000_0001);
    tick();
    setR(6'h00, 6'h02, 6'h00);
    #1;
    check("t2_B", bus0.rdDataB, 32'h0);
    setW(1'b1, 6'h02, 32'hFFFF_FFFF);
    setR(6'h01, 6'h02, 6'h01);
    #1;
`ifdef RF_WRITE_BYPASS_EN
    check("t3_pre", bus0.rdDataB, 32'hFFFF_FFFF);
`else
    check("t3_pre", bus0.rdDataB, 32'h0);
`endif
    check("t3_preA", bus0.rdDataA, 32'h1457_8BB0);
    tick();
    setW(1'b0, '0, '0);
    #1;
    check("t3_post", bus0.rdDataB, 32'hFFFF_FFFF);
    setW(1'b1, 6'h00, 32'h8888_8888);
    tick();
    setW(1'b1, 6'h3F, 32'h0000_0001);
    tick();
    setW(1'b0, '0, '0);
    setR(6'h3F, 6'h00, 6'h3F);
    #1;
    check("t4_A", bus0.rdDataA, 32'h0000_0001);
    check("t4_B", bus0.rdDataB, 32'h8888_8888);
    setW(1'b1, 6'h00, 32'hDDDD_DDDD);
    tick();
    setW(1'b0, '0, '0);
    setR(6'h3F, 6'h02, 6'h3F);
    #1;
    check("t5_A", bus0.rdDataA, 32'h0000_0001);
    check("t5_B", bus0.rdDataB, 32'hFFFF_FFFF);
    check("t5_C", bus0.rdDataC, 32'h0000_0001);
    setR(6'h00, 6'h00, 6'h00);
    #1;
    check("t5_r0", bus0.rdDataA, 32'hDDDD_DDDD);
    rst_n = 1'b0;
    setW(1'b1, 6'h05, 32'h1234_5678);
    setR(6'h05, 6'h00, 6'h3F);
    #1;
    check("t6_preA", bus0.rdDataA, 32'h0);
    check("t6_preB", bus0.rdDataB, 32'hDDDD_DDDD);
    tick();
    rst_n = 1'b1;
    setW(1'b0, '0, '0);
    #1;
    check("t6_A", bus0.rdDataA, 32'h0);
    check("t6_B", bus0.rdDataB, 32'h0);
    check("t6_C", bus0.rdDataC, 32'h0);
    check("t6_A1", bus1.rdDataA, 32'h0);
    setR(6'h01, 6'h02, 6'h3F);
    checkPorts("t6m");
    for (int n = 0; n < 400; n++) begin
      addr_t wa;
      rst_n = ($urandom_range(0, 29) != 0);
      wa = addr_t'($urandom_range(0, NUM_REGS - 1));
      setW(logic'($urandom_range(0, 1)), wa, $urandom);
      setR(($urandom_range(0, 3) == 0) ? wa : addr_t'($urandom_range(0, NUM_REGS - 1)),
           ($urandom_range(0, 3) == 0) ? wa : addr_t'($urandom_range(0, NUM_REGS - 1)),
           ($urandom_range(0, 3) == 0) ? wa : addr_t'($urandom_range(0, NUM_REGS - 1)));
      checkPorts("rnd");
      tick();
    end
    rst_n = 1'b1;
    setW(1'b0, '0, '0);
    checkPorts("end");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
